// File: rtl/wrr_arb_ctrl.sv
// wrr_arb_ctrl: weighted round-robin arbiter. A winner keeps the resource for
// up to its weight in beats, then ownership rotates to the next requester.
// Optional feature macro: WRR_ARB_LOCK_EN adds i_lock; while the owner holds
// request and lock, its quota is frozen and no rotation happens.
module wrr_arb_ctrl #(
  parameter int N  = 4,
  parameter int WW = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N-1:0]          i_request,
`ifdef WRR_ARB_LOCK_EN
  input  logic                  i_lock,
`endif
  input  logic [N*WW-1:0]       i_weight_cfg,
  output logic [N-1:0]          o_grant,
  output logic [$clog2(N)-1:0]  o_grant_id,
  output logic                  o_grant_valid,
  output logic [WW-1:0]         o_beats_left
);
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic [IW-1:0]   r_gid, w_gid_nxt;
  logic [WW-1:0]   r_cnt, w_cnt_nxt;
  logic [N-1:0]    r_grant, w_grant_nxt;

  logic [IW-1:0]   w_after;   // owner index + 1, mod N
  logic [IW-1:0]   w_base;    // scan start for the arbiter
  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [WW-1:0]   w_win_wt;  // winner quota, 0 promoted to 1
  logic            w_own_req;
  logic            w_hold;

  assign w_after   = (r_gid == IW'(N-1)) ? '0 : r_gid + 1'b1;
  assign w_base    = (r_state == IDLE) ? r_ptr : w_after;
  assign w_own_req = i_request[r_gid];
`ifdef WRR_ARB_LOCK_EN
  assign w_hold    = i_lock & w_own_req;
`else
  assign w_hold    = 1'b0;
`endif

  // Round-robin scan: first set request bit from w_base upward with wrap.
  // On rotation the current owner is naturally the last candidate, which
  // gives the re-grant-on-exhaustion behaviour when nobody else asks.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && i_request[IW'((int'(w_base) + k) % N)]) begin
        w_found = 1'b1;
        w_win   = IW'((int'(w_base) + k) % N);
      end
    end
    w_win_wt = i_weight_cfg[w_win*WW +: WW];
    if (w_win_wt == '0) w_win_wt = WW'(1);
  end

  // Next-state / next-output logic for the IDLE/OWN controller.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gid_nxt   = r_gid;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = OWN;
          w_gid_nxt   = w_win;
          w_grant_nxt = N'(1) << w_win;
          w_cnt_nxt   = w_win_wt;
        end
      end
      OWN: begin
        if (!w_own_req || (!w_hold && r_cnt == WW'(1))) begin
          // Release or quota exhausted: rotate and hand over without a bubble.
          w_ptr_nxt = w_after;
          if (w_found) begin
            w_gid_nxt   = w_win;
            w_grant_nxt = N'(1) << w_win;
            w_cnt_nxt   = w_win_wt;
          end else begin
            w_state_nxt = IDLE;
            w_gid_nxt   = '0;
            w_grant_nxt = '0;
            w_cnt_nxt   = '0;
          end
        end else if (!w_hold) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset clears everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gid   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gid   <= w_gid_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_id    = r_gid;
  assign o_grant_valid = |r_grant;
  assign o_beats_left  = r_cnt;
endmodule

// File: tb/tb_wrr_arb_ctrl.sv
// Bench for wrr_arb_ctrl: directed scenarios with hand-derived expectations,
// then a random phase checked against a behavioural model via a scoreboard.
module tb_wrr_arb_ctrl;
  localparam int N  = 4;
  localparam int WW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            lock;
  logic [N-1:0]    req;
  logic [N*WW-1:0] wcfg;
  logic [N-1:0]    grant;
  logic [1:0]      gid;
  logic            gvld;
  logic [WW-1:0]   beats;

  always #5 clk = ~clk;

  wrr_arb_ctrl #(.N(N), .WW(WW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_request    (req),
`ifdef WRR_ARB_LOCK_EN
    .i_lock       (lock),
`endif
    .i_weight_cfg (wcfg),
    .o_grant      (grant),
    .o_grant_id   (gid),
    .o_grant_valid(gvld),
    .o_beats_left (beats)
  );

  typedef struct {
    logic [N-1:0]  g;
    logic [WW-1:0] b;
    string         tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model of the arbiter.
  int m_own, m_ptr, m_gid, m_cnt;

  function automatic int pick(input int from);
    for (int k = 0; k < N; k++)
      if (req[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  function automatic int wt(input int i);
    int v;
    v = int'(wcfg[i*WW +: WW]);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_step();
    int w;
    if (rst) begin
      m_own = 0; m_ptr = 0; m_gid = 0; m_cnt = 0;
    end else if (m_own == 0) begin
      w = pick(m_ptr);
      if (w >= 0) begin m_own = 1; m_gid = w; m_cnt = wt(w); end
    end else if (!req[m_gid] || (!lock && m_cnt == 1)) begin
      m_ptr = (m_gid + 1) % N;
      w = pick(m_ptr);
      if (w >= 0) begin m_gid = w; m_cnt = wt(w); end
      else begin m_own = 0; m_gid = 0; m_cnt = 0; end
    end else if (!lock) begin
      m_cnt = m_cnt - 1;
    end
  endtask

  // One cycle: drive on the falling edge, push expectation, compare after rise.
  task automatic step(input logic r, input logic [N-1:0] rq, input bit use_c,
                      input logic [N-1:0] eg, input int eb, input string tag);
    exp_t e;
    int   egid;
    @(negedge clk);
    rst = r;
    req = rq;
    model_step();
    e.tag = tag;
    if (use_c) begin
      e.g = eg;
      e.b = WW'(eb);
    end else begin
      e.g = (m_own != 0) ? N'(1) << m_gid : '0;
      e.b = WW'(m_cnt);
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    egid = 0;
    for (int i = 0; i < N; i++) if (e.g[i]) egid = i;
    chk({e.tag, ".grant"}, 32'(grant), 32'(e.g));
    chk({e.tag, ".gid"},   32'(gid),   32'(egid));
    chk({e.tag, ".valid"}, 32'(gvld),  32'(|e.g));
    chk({e.tag, ".beats"}, 32'(beats), 32'(e.b));
  endtask

  initial begin
    rst  = 1'b1;
    lock = 1'b0;
    req  = '0;
    wcfg = '0;

    // Reset state
    step(1, 4'b0000, 1, 4'b0000, 0, "reset");

    // Two requesters, weights 2: alternate every 2 beats, no bubble
    wcfg = 16'h2222;
    step(0, 4'b1010, 1, 4'b0010, 2, "alt0");
    step(0, 4'b1010, 1, 4'b0010, 1, "alt1");
    step(0, 4'b1010, 1, 4'b1000, 2, "alt2");
    step(0, 4'b1010, 1, 4'b1000, 1, "alt3");
    step(0, 4'b1010, 1, 4'b0010, 2, "alt4");

    // Lone requester re-granted with reloaded quota
    step(1, 4'b0000, 1, 4'b0000, 0, "rst2");
    wcfg = 16'h0003;
    step(0, 4'b0001, 1, 4'b0001, 3, "solo0");
    step(0, 4'b0001, 1, 4'b0001, 2, "solo1");
    step(0, 4'b0001, 1, 4'b0001, 1, "solo2");
    step(0, 4'b0001, 1, 4'b0001, 3, "solo3");
    step(0, 4'b0001, 1, 4'b0001, 2, "solo4");
    step(0, 4'b0001, 1, 4'b0001, 1, "solo5");
    step(0, 4'b0001, 1, 4'b0001, 3, "solo6");

    // Owner 2 releases early, grant moves to 3 on the next edge
    step(1, 4'b0000, 1, 4'b0000, 0, "rst3");
    wcfg = 16'h2400;
    step(0, 4'b0100, 1, 4'b0100, 4, "rel0");
    step(0, 4'b0100, 1, 4'b0100, 3, "rel1");
    step(0, 4'b1000, 1, 4'b1000, 2, "rel2");
    step(0, 4'b0000, 1, 4'b0000, 0, "rel_idle");

    // Reset mid-ownership, then restart favouring requester 0; zero weights
    step(1, 4'b0000, 1, 4'b0000, 0, "rst4");
    wcfg = 16'h0030;
    step(0, 4'b0010, 1, 4'b0010, 3, "mid0");
    step(0, 4'b0010, 1, 4'b0010, 2, "mid1");
    step(1, 4'b0010, 1, 4'b0000, 0, "mid_rst");
    step(0, 4'b1111, 1, 4'b0001, 1, "all0");
    step(0, 4'b1111, 1, 4'b0010, 3, "all1");
    step(0, 4'b1111, 1, 4'b0010, 2, "all2");
    step(0, 4'b1111, 1, 4'b0010, 1, "all3");
    step(0, 4'b1111, 1, 4'b0100, 1, "all4");
    step(0, 4'b1111, 1, 4'b1000, 1, "all5");
    step(0, 4'b1111, 1, 4'b0001, 1, "all6");

`ifdef WRR_ARB_LOCK_EN
    // Lock freezes quota and rotation
    step(1, 4'b0000, 1, 4'b0000, 0, "rst5");
    wcfg = 16'h0011;
    lock = 1'b1;
    step(0, 4'b0011, 1, 4'b0001, 1, "lock0");
    for (int i = 0; i < 4; i++) step(0, 4'b0011, 1, 4'b0001, 1, "lockh");
    lock = 1'b0;
    step(0, 4'b0011, 1, 4'b0010, 1, "unlock");
`endif

    // Random traffic against the model
    step(1, 4'b0000, 0, '0, 0, "rst_rnd");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) wcfg = 16'($urandom);
`ifdef WRR_ARB_LOCK_EN
      lock = ($urandom_range(0, 3) == 0);
`endif
      step(($urandom_range(0, 63) == 0), N'($urandom), 0, '0, 0, "rnd");
      chk("onehot", 32'($countones(grant) <= 1), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/wrr_arb_ctrl.md
WRR_ARB_CTRL -- requirements
Module: wrr_arb_ctrl

Interface
REQ-001 Parameter N, default 4; number of requesters, 2..8.
REQ-002 Parameter WW, default 4; weight field width per requester.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 request  input  N  per-requester request; bit i high = requester i wants the shared resource.
REQ-006 weight_cfg  input  N*WW  per-requester quota in beats; field i = bits [i*WW +: WW].
REQ-007 grant  output  N  one-hot grant, registered; all-zero when idle.
REQ-008 grant_id  output  clog2(N)  index of granted requester; 0 when idle.
REQ-009 grant_valid  output  1  high when grant is non-zero.
REQ-010 beats_left  output  WW  remaining quota of current owner; 0 when idle.

Function
REQ-011 The block SHALL implement states IDLE and OWN, with a round-robin pointer ptr (clog2(N) bits) and quota counter cnt (WW bits).
REQ-012 IDLE: any request bit high SHALL cause the winner to be the first set bit scanning from ptr upward with wrap-around; state goes to OWN and grant asserts on the next edge (1-cycle request-to-grant latency).
REQ-013 On every grant, cnt SHALL load weight_cfg field of the winner, sampled that same edge; a weight of 0 SHALL be treated as 1.
REQ-014 OWN, owner i: each cycle with request[i] high SHALL consume one beat; cnt decrements; beats_left = cnt.
REQ-015 OWN, request[i] low: release; ptr SHALL become i+1 mod N; if other requests are high, next winner (scan from i+1, excluding i) SHALL be granted on the same edge (no idle bubble); else go to IDLE with grant=0.
REQ-016 OWN, cnt==1 and request[i] high: quota exhausted; ptr SHALL become i+1 mod N; next winner chosen as in REQ-015; if no other request is high, i SHALL be re-granted with quota reloaded, no bubble.
REQ-017 grant SHALL be one-hot or zero on every cycle; grant_valid == |grant; grant_id consistent with grant.
REQ-018 A requester dropping request while not granted SHALL have no effect; request need not be held until grant.
REQ-019 weight_cfg changes SHALL only affect grants issued after the change; the current cnt is not reloaded.
REQ-020 Worst-case wait for a continuously requesting input SHALL be the sum of the other N-1 quotas plus 1 cycle.

Reset
REQ-021 rst high at any edge, including mid-ownership, SHALL force state=IDLE, ptr=0, cnt=0, grant=0, grant_id=0, grant_valid=0, beats_left=0 on that edge.
REQ-022 First grant after reset release SHALL favour requester 0 when multiple requests are high.

Configuration
REQ-023 Macro WRR_ARB_LOCK_EN: when defined, an extra input lock (1 bit, placed after request) SHALL exist; while owner holds request and lock high, cnt SHALL not decrement and quota exhaustion SHALL not rotate; ptr update still occurs on release.
REQ-024 Without WRR_ARB_LOCK_EN, no lock port exists and quota is always enforced per REQ-016.

Verification
REQ-025 Reset then request=4'b1010 held, weights all 2 -> grant 0010 for 2 cycles, then 1000 for 2, then 0010; no zero-grant cycles between.
REQ-026 request=4'b0001 only, weight0=3, held 7 cycles -> grant 0001 continuously, beats_left sequence 3,2,1,3,2,1,3.
REQ-027 Owner 2 drops request after 1 beat of weight 4, request[3] high -> grant moves to 1000 on the next edge, ptr=3.
REQ-028 rst pulsed 1 cycle while owner 1 has beats_left=2 -> next edge all outputs 0; after release with request=4'b1111 grant=0001.
REQ-029 weight field = 0 with request held -> that requester granted exactly 1 beat per turn.
REQ-030 WRR_ARB_LOCK_EN defined, owner 0 weight 1, lock high 5 cycles with request[1] high -> grant stays 0001 until lock drops, then 0010 next edge.
